run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
Synthesizable run-control sequencer for the single-cycle core, and a parametrised successor to the hand-timed bench sequence of reset pulse, enable and fixed-delay stop. It generates the core reset pulse and gates the core enable. It counts executed cycles against a programmable budget and supports free-run, single-step and external-halt modes. It sits between the top-level MAIN wrapper / bench and the core's rst/en inputs.

Parameters:
CNT_W, 16, width of the cycle budget and cycle counter.
RST_CYCLES, 2, core_rst pulse length in clk cycles (>=1).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset; all state cleared while low.
start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
step_mode  input  1  sampled at start; 1 = single-step, 0 = free-run.
step_req  input  1  pulse; grants one enabled cycle while in STEP_WAIT.
halt_req  input  1  level; forces a stop from RUN or STEP_WAIT.
budget  input  CNT_W  cycles to run, sampled at start; 0 = unlimited.
core_rst  output  1  active-high reset pulse to the core.
core_en  output  1  core enable.
cycles  output  CNT_W  enabled cycles executed in the current run.
busy  output  1  high in RESET, RUN and STEP_WAIT.
done  output  1  high in DONE.
timeout  output  1  high in DONE when the stop was caused by the budget.

Behaviour:
- Reset (rst low): state=IDLE; core_rst=0, core_en=0, cycles=0, busy=0, done=0, timeout=0. Also sampled registers mode_q=0, budget_q=0, rcnt=0.
- All outputs are registered; state decodes come from flops, not inputs.
- IDLE: start -> RESET. Latch mode_q=step_mode and budget_q=budget, clear cycles, clear timeout, load rcnt=RST_CYCLES-1.
- RESET: core_rst=1 for exactly RST_CYCLES cycles. Then go to RUN if mode_q=0, else STEP_WAIT. core_en=0 throughout.
- RUN: core_en=1 each cycle, and cycles increments on every cycle core_en=1.
  - Exit to DONE when halt_req=1 (core_en drops the same edge, no further increment).
  - Exit to DONE when budget_q!=0 and cycles+1==budget_q. The final enabled cycle is counted, cycles==budget_q in DONE, timeout=1.
- STEP_WAIT: core_en=0 by default. step_req=1 -> core_en=1 for exactly one cycle and cycles+=1. step_req held high steps once per cycle. The budget rule applies as in RUN.
- halt_req has priority over step_req and the budget. On a simultaneous halt and budget hit, timeout=0 and the state goes to DONE.
- DONE: done=1, cycles frozen, core_en=0. start -> RESET, which begins a new run (re-latches inputs, clears cycles and timeout).
- start is ignored while busy=1; it never restarts a run in progress.
- Counter saturates at all-ones when budget_q=0: no wrap, stays in RUN.
- Async rst asserted mid-run returns to IDLE immediately with core_en=0 and core_rst=0. The core is only re-reset by the next start.
- halt_req asserted during RESET: the pulse completes, then the state goes straight to DONE with cycles=0.

Optional Feature:
Macro RUN_CTRL_STALL_CNT_EN.
- Defined: adds output stall_cycles[CNT_W].
  - Counts cycles spent in STEP_WAIT with core_en=0, saturating.
  - Cleared on rst and on entry to RESET; frozen in DONE.
- Undefined: port and counter absent; all other behaviour is identical.

Decomposition:
- Package run_ctrl_pkg holds:
  - state enum IDLE/RESET/RUN/STEP_WAIT/DONE (3-bit encoding);
  - localparam default CNT_W;
  - helper constant for the saturation value.
- Sub-module sat_counter (width param, clear, inc, saturating) is shared by cycles and stall_cycles. The FSM stays in run_ctrl.

Test Plan:
- Free-run budget: RST_CYCLES=2, start with step_mode=0, budget=10.
  - core_rst high 2 cycles, then core_en high exactly 10 cycles.
  - DONE with cycles=10, timeout=1.
- Unlimited budget plus halt: budget=0, halt_req asserted after 25 enabled cycles.
  - core_en falls the same edge; cycles=25, timeout=0, done=1.
- Single-step: step_mode=1, budget=3, 5 step_req pulses spaced 4 cycles apart.
  - Exactly 3 one-cycle core_en pulses, then DONE, cycles=3, timeout=1.
  - With the macro defined, stall_cycles is non-zero and equals the STEP_WAIT idle count.
- Simultaneous halt and budget: budget=4, halt_req rises on the 4th enabled cycle.
  - DONE, cycles=4, timeout=0.
- Reset mid-run: rst low for 1 cycle during RUN at cycles=7.
  - All outputs return to their reset values asynchronously.
  - A subsequent start re-pulses core_rst and counts from 0.
- Restart from DONE plus ignored start: a start during RUN has no effect.
  - A start in DONE with budget=2 gives a new run ending at cycles=2.

Source files
------------

// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the run_ctrl sequencer and its counters.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RESET     = 3'd1,
        RUN       = 3'd2,
        STEP_WAIT = 3'd3,
        DONE      = 3'd4
    } state_t;

    localparam int unsigned DEF_CNT_W = 16;

    // Saturation value of a default-width counter.
    localparam logic [DEF_CNT_W-1:0] DEF_CNT_SAT = '1;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; shared by the cycle and stall counters.
module sat_counter
    import run_ctrl_pkg::*;
#(
    parameter int unsigned W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run-control sequencer: core reset pulse, enable gating, cycle budget, step/halt modes.
// Optional stall counter output enabled by defining RUN_CTRL_STALL_CNT_EN.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = DEF_CNT_W,
    parameter int unsigned RST_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step_mode,
    input  logic             step_req,
    input  logic             halt_req,
    input  logic [CNT_W-1:0] budget,
    output logic             core_rst,
    output logic             core_en,
    output logic [CNT_W-1:0] cycles,
    output logic             busy,
    output logic             done,
    output logic             timeout
`ifdef RUN_CTRL_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles
`endif
);

    localparam int unsigned RCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    logic [CNT_W-1:0]   budget_q, budget_d;
    logic [RCNT_W-1:0]  rcnt_q, rcnt_d;
    logic               timeout_d;
    logic               en_d;
    logic               clr;
    logic               budget_hit;

    // The enabled cycle that ends at this edge is the last one the budget allows.
    assign budget_hit = core_en && (budget_q != '0) && (cycles == budget_q - CNT_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            mode_q   <= 1'b0;
            budget_q <= '0;
            rcnt_q   <= '0;
            core_rst <= 1'b0;
            core_en  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            budget_q <= budget_d;
            rcnt_q   <= rcnt_d;
            core_rst <= (state_d == RESET);
            core_en  <= en_d;
            busy     <= (state_d == RESET) || (state_d == RUN) || (state_d == STEP_WAIT);
            done     <= (state_d == DONE);
            timeout  <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        budget_d  = budget_q;
        rcnt_d    = rcnt_q;
        timeout_d = timeout;
        en_d      = 1'b0;
        clr       = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RESET;
                    mode_d    = step_mode;
                    budget_d  = budget;
                    rcnt_d    = RCNT_W'(RST_CYCLES - 1);
                    timeout_d = 1'b0;
                    clr       = 1'b1;
                end
            end
            RESET: begin
                if (rcnt_q == '0) begin
                    if (halt_req) begin
                        state_d = DONE;
                    end else if (mode_q) begin
                        state_d = STEP_WAIT;
                    end else begin
                        state_d = RUN;
                        en_d    = 1'b1;
                    end
                end else begin
                    rcnt_d = rcnt_q - RCNT_W'(1);
                end
            end
            RUN, STEP_WAIT: begin
                // Halt outranks the budget, so a coincident hit leaves timeout low.
                if (halt_req) begin
                    state_d = DONE;
                end else if (budget_hit) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    en_d = (state_q == RUN) ? 1'b1 : step_req;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (core_en),
        .count (cycles)
    );

`ifdef RUN_CTRL_STALL_CNT_EN
    sat_counter #(.W(CNT_W)) u_stall (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   ((state_q == STEP_WAIT) && !core_en),
        .count (stall_cycles)
    );
`endif

endmodule

// File: tb/tb_run_ctrl.sv
// Scoreboard bench for run_ctrl: expected run results queued at start, checked when done rises.
module tb_run_ctrl;

    localparam int unsigned CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             step_mode;
    logic             step_req;
    logic             halt_req;
    logic [CNT_W-1:0] budget;
    logic             core_rst;
    logic             core_en;
    logic [CNT_W-1:0] cycles;
    logic             busy;
    logic             done;
    logic             timeout;
`ifdef RUN_CTRL_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cycles;
`endif

    run_ctrl #(.CNT_W(CNT_W), .RST_CYCLES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .step_mode (step_mode),
        .step_req  (step_req),
        .halt_req  (halt_req),
        .budget    (budget),
        .core_rst  (core_rst),
        .core_en   (core_en),
        .cycles    (cycles),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
`ifdef RUN_CTRL_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        int unsigned cyc;
        int unsigned to;
        int unsigned en;
        int unsigned rl;
        int unsigned pl;
        int unsigned st;
    } exp_t;

    exp_t expq[$];
    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_exp(input string tag, input int unsigned cyc, input int unsigned to,
                            input int unsigned en, input int unsigned rl, input int unsigned pl,
                            input int unsigned st);
        exp_t e;
        e.tag = tag; e.cyc = cyc; e.to = to; e.en = en; e.rl = rl; e.pl = pl; e.st = st;
        expq.push_back(e);
    endtask

    task automatic pulse_start(input logic mode, input logic [CNT_W-1:0] bud);
        start = 1'b1; step_mode = mode; budget = bud;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (done) return;
            @(negedge clk);
        end
        check_val({tag, "_wait_done"}, 32'd0, 32'd1);
    endtask

    task automatic wait_cycles(input string tag, input int unsigned val, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (core_en && cycles == CNT_W'(val)) return;
            @(negedge clk);
        end
        check_val({tag, "_wait_cycles"}, 32'd0, 32'd1);
    endtask

    // Monitor: observes run shape from outputs and retires one scoreboard entry per done rise.
    initial begin
        int unsigned m_rst, m_en, m_pl;
        logic en_prev, done_prev;
        exp_t e;
        m_rst = 0; m_en = 0; m_pl = 0; en_prev = 1'b0; done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_rst = 0; m_en = 0; m_pl = 0;
            end else begin
                if (core_rst) m_rst++;
                if (core_en) m_en++;
                if (core_en && !en_prev) m_pl++;
                if (done && !done_prev) begin
                    if (expq.size() == 0) begin
                        check_val("sb_unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = expq.pop_front();
                        check_val({e.tag, "_cycles"},  32'(cycles), e.cyc);
                        check_val({e.tag, "_timeout"}, 32'(timeout), e.to);
                        check_val({e.tag, "_busy"},    32'(busy), 32'd0);
                        check_val({e.tag, "_en_cnt"},  m_en, e.en);
                        check_val({e.tag, "_rst_len"}, m_rst, e.rl);
                        check_val({e.tag, "_en_puls"}, m_pl, e.pl);
`ifdef RUN_CTRL_STALL_CNT_EN
                        check_val({e.tag, "_stall"},   32'(stall_cycles), e.st);
`endif
                    end
                    m_rst = 0; m_en = 0; m_pl = 0;
                end
            end
            en_prev = core_en;
            done_prev = done;
        end
    end

    initial begin
        rst = 1'b0; start = 1'b0; step_mode = 1'b0; step_req = 1'b0; halt_req = 1'b0; budget = '0;
        repeat (3) @(negedge clk);
        check_val("rst_core_rst", 32'(core_rst), 32'd0);
        check_val("rst_core_en",  32'(core_en), 32'd0);
        check_val("rst_cycles",   32'(cycles), 32'd0);
        check_val("rst_busy",     32'(busy), 32'd0);
        check_val("rst_done",     32'(done), 32'd0);
        check_val("rst_timeout",  32'(timeout), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Free-run with budget 10.
        push_exp("free10", 10, 1, 10, 2, 1, 0);
        pulse_start(1'b0, 16'd10);
        wait_done("free10", 100);

        // Unlimited budget, halt sampled at the edge ending the 25th enabled cycle.
        push_exp("halt25", 25, 0, 25, 2, 1, 0);
        pulse_start(1'b0, 16'd0);
        wait_cycles("halt25", 24, 100);
        halt_req = 1'b1;
        @(negedge clk);
        wait_done("halt25", 10);
        halt_req = 1'b0;

        // Single-step, budget 3, five requests four cycles apart.
        push_exp("step3", 3, 1, 3, 2, 3, 7);
        pulse_start(1'b1, 16'd3);
        for (int i = 0; i < 20; i++) begin
            if (busy && !core_rst) break;
            @(negedge clk);
        end
        for (int k = 0; k < 5; k++) begin
            step_req = 1'b1;
            @(negedge clk);
            step_req = 1'b0;
            repeat (3) @(negedge clk);
        end
        wait_done("step3", 20);

        // Halt coincides with the budget hit: halt wins, timeout stays low.
        push_exp("hb4", 4, 0, 4, 2, 1, 0);
        pulse_start(1'b0, 16'd4);
        wait_cycles("hb4", 3, 50);
        halt_req = 1'b1;
        @(negedge clk);
        wait_done("hb4", 10);
        halt_req = 1'b0;

        // Halt held through RESET: pulse completes, then straight to DONE.
        halt_req = 1'b1;
        push_exp("rhalt", 0, 0, 0, 2, 0, 0);
        pulse_start(1'b0, 16'd5);
        wait_done("rhalt", 20);
        halt_req = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of a run.
        pulse_start(1'b0, 16'd0);
        wait_cycles("mid", 7, 50);
        rst = 1'b0;
        #1;
        check_val("mid_core_rst", 32'(core_rst), 32'd0);
        check_val("mid_core_en",  32'(core_en), 32'd0);
        check_val("mid_cycles",   32'(cycles), 32'd0);
        check_val("mid_busy",     32'(busy), 32'd0);
        check_val("mid_done",     32'(done), 32'd0);
        check_val("mid_timeout",  32'(timeout), 32'd0);
`ifdef RUN_CTRL_STALL_CNT_EN
        check_val("mid_stall",    32'(stall_cycles), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        push_exp("post_rst", 5, 1, 5, 2, 1, 0);
        pulse_start(1'b0, 16'd5);
        wait_done("post_rst", 50);

        // Start during RUN is ignored; start from DONE begins a fresh run.
        push_exp("ign", 20, 1, 20, 2, 1, 0);
        pulse_start(1'b0, 16'd20);
        wait_cycles("ign", 5, 50);
        check_val("ign_busy", 32'(busy), 32'd1);
        pulse_start(1'b1, 16'd3);
        wait_done("ign", 100);
        push_exp("restart2", 2, 1, 2, 2, 1, 0);
        pulse_start(1'b0, 16'd2);
        check_val("restart_done_low", 32'(done), 32'd0);
        wait_done("restart2", 50);

        repeat (3) @(negedge clk);
        check_val("sb_empty", 32'(expq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
